// File: rtl/and_reduce_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// and_reduce_sequencer_pkg
//   Shared definitions for the serial AND reduction engine:
//     - state_t        : FSM state encoding (IDLE=0, ACCUM=1, DONE=2), also
//                        driven out of the top level as a debug view.
//     - DEFAULT_WIDTH  : default operand/result width.
//     - DEFAULT_NUM_OPS: default number of operands per reduction.
//     - count_width()  : width of the operand counter for a given NUM_OPS.
// -----------------------------------------------------------------------------
package and_reduce_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_NUM_OPS = 3;

  // The counter must be able to hold the value NUM_OPS itself, because
  // op_count reads NUM_OPS while the result waits in DONE.
  function automatic int count_width(input int num_ops);
    return $clog2(num_ops + 1);
  endfunction

endpackage

// File: rtl/and_reduce_sequencer_accum_reg.sv
// -----------------------------------------------------------------------------
// and_accum_reg
//   Registered bitwise-AND accumulator shared by every operand of a reduction.
//   Ports:
//     clk   in  1      rising-edge clock
//     rst_n in  1      asynchronous active-low reset, clears q
//     load  in  1      q <= d (first operand, or d=0 to wipe the accumulator)
//     en    in  1      q <= q & d (subsequent operands); load wins over en
//     d     in  WIDTH  operand
//     q     out WIDTH  accumulated value
// -----------------------------------------------------------------------------
module and_accum_reg
  import and_reduce_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= q & d;
    end
  end

endmodule

// File: rtl/and_reduce_sequencer.sv
// -----------------------------------------------------------------------------
// and_reduce_sequencer
//   Serial multi-operand AND reduction. NUM_OPS operands arrive one at a time
//   on the input stream, are folded into a single WIDTH-bit AND accumulator,
//   and the result is offered on the output stream. Trades latency for the
//   area of a wide parallel N-input AND.
//
//   Handshake rule (both streams): a transfer happens on a rising clock edge
//   where valid and ready are both high. in_ready and out_valid are decoded
//   from registered state only, so there is no combinational path from
//   in_valid to in_ready nor from out_ready to out_valid. in_ready is high in
//   IDLE/ACCUM and low in DONE; out_valid is high only in DONE.
//
//   Ports:
//     clk       in  1      rising-edge clock
//     rst_n     in  1      asynchronous active-low reset
//     clear     in  1      synchronous abort back to IDLE (beats any transfer)
//     in_valid  in  1      operand valid
//     in_ready  out 1      operand ready
//     in_data   in  WIDTH  operand
//     out_valid out 1      result valid
//     out_ready in  1      result ready
//     out_data  out WIDTH  AND of the NUM_OPS accepted operands
//     busy      out 1      high in ACCUM or DONE
//     op_count  out CW     operands accepted so far, CW = $clog2(NUM_OPS+1)
//     state     out 2      current FSM state (debug view)
// -----------------------------------------------------------------------------
module and_reduce_sequencer
  import and_reduce_sequencer_pkg::*;
#(
  parameter  int WIDTH   = DEFAULT_WIDTH,
  parameter  int NUM_OPS = DEFAULT_NUM_OPS,
  localparam int CW      = count_width(NUM_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CW-1:0]    op_count,
  output state_t           state
);

  if (NUM_OPS < 2) begin : g_bad_num_ops
    $error("and_reduce_sequencer: NUM_OPS must be at least 2");
  end

  logic             in_xfer;
  logic             out_xfer;
  logic             last_op;
  logic             acc_load;
  logic             acc_en;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // The operand being accepted now is the final one when op_count already
  // holds NUM_OPS-1.
  assign last_op  = (op_count == CW'(NUM_OPS - 1));

  // clear reuses the load path with a zero operand so the accumulator is
  // wiped in the same cycle the FSM returns to IDLE.
  assign acc_load = clear | ((state == ST_IDLE) & in_xfer);
  assign acc_en   = ~clear & (state == ST_ACCUM) & in_xfer;
  assign acc_d    = clear ? '0 : in_data;

  and_accum_reg #(
    .WIDTH (WIDTH)
  ) u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (acc_load),
    .en    (acc_en),
    .d     (acc_d),
    .q     (acc)
  );

  // FSM with every output registered. in_ready resets low and rises on the
  // first edge after reset release, then tracks "next state is not DONE".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_count  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else if (clear) begin
      // Any same-cycle input transfer and any pending result are dropped.
      state     <= ST_IDLE;
      op_count  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            state    <= ST_ACCUM;
            op_count <= CW'(1);
            busy     <= 1'b1;
          end
        end

        ST_ACCUM: begin
          if (in_xfer) begin
            op_count <= op_count + CW'(1);
            if (last_op) begin
              // The accumulator updates on this same edge, so the result is
              // formed from acc and the final operand directly.
              state     <= ST_DONE;
              out_data  <= acc & in_data;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          // Result, op_count and in_ready hold until the consumer takes it.
          if (out_xfer) begin
            state     <= ST_IDLE;
            op_count  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          op_count  <= '0;
          out_valid <= 1'b0;
          out_data  <= '0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
